// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan driver.
// Holds the blank pattern, digit count, digit index type and hex table.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef logic [1:0] digit_idx_t;

   // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for nibble n.
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low 7-segment lookup.
// Ports: nibble (4b in), seg (7b out, {g,f,e,d,c,b,a}, active-low).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed hex display plus 8-LED bar.
// Ports: clk, reset_cpu (sync, active-high), output_port[15:0],
//   PC_below8bit[7:0], freeze -> seg[6:0], an[3:0], led[7:0],
//   frame_tick. Define SEG7_LEAD_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 20
) (
   input  logic        clk,
   input  logic        reset_cpu,
   input  logic [15:0] output_port,
   input  logic [7:0]  PC_below8bit,
   input  logic        freeze,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [7:0]  led,
   output logic        frame_tick
);

   logic [CNT_W-1:0] refresh_cnt;
   digit_idx_t       digit_idx;
   logic [15:0]      disp_val;

   logic       wrap;
   logic       frame_end;
   logic       latch;
   logic [3:0] nibble;
   logic [6:0] hex_seg;
   logic [6:0] seg_next;
   logic       blank;

   assign wrap      = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = wrap && (digit_idx == digit_idx_t'(NUM_DIGITS - 1));
   assign latch     = frame_end && !freeze;
   assign nibble    = disp_val[{digit_idx, 2'b00} +: 4];

   hex_to_seg7 u_hex (
      .nibble (nibble),
      .seg    (hex_seg)
   );

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   digit_idx_t msd;

   // msd stays 0 for an all-zero value so digit 0 always shows.
   always_comb begin
      msd = 2'd0;
      if (disp_val[7:4]   != 4'h0) msd = 2'd1;
      if (disp_val[11:8]  != 4'h0) msd = 2'd2;
      if (disp_val[15:12] != 4'h0) msd = 2'd3;
      blank = (digit_idx > msd);
   end
`else
   assign blank = 1'b0;
`endif

   assign seg_next = blank ? SEG_BLANK : hex_seg;

   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
         disp_val    <= '0;
         seg         <= SEG_BLANK;
         an          <= 4'b1111;
         led         <= '0;
         frame_tick  <= 1'b0;
      end else begin
         if (wrap) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
         if (latch) disp_val <= output_port;
         if (!freeze) led <= PC_below8bit;
         frame_tick <= latch;
         an         <= ~(4'b0001 << digit_idx);
         seg        <= seg_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan, latch, freeze, reset.
// Runs a REFRESH_DIV=4 instance and a REFRESH_DIV=1 instance.
module tb_seg7_scan_driver;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [3:0][3:0] AN_EXP =
      {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   logic        clk = 1'b0;
   logic        reset_cpu;
   logic [15:0] output_port;
   logic [7:0]  pc;
   logic        freeze;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [7:0]  led;
   logic        frame_tick;

   logic [15:0] port1;
   logic [7:0]  pc1;
   logic        freeze1;
   logic [6:0]  seg1;
   logic [3:0]  an1;
   logic [7:0]  led1;
   logic        tick1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(4), .CNT_W(20)) dut (
      .clk          (clk),
      .reset_cpu    (reset_cpu),
      .output_port  (output_port),
      .PC_below8bit (pc),
      .freeze       (freeze),
      .seg          (seg),
      .an           (an),
      .led          (led),
      .frame_tick   (frame_tick)
   );

   seg7_scan_driver #(.REFRESH_DIV(1), .CNT_W(20)) dut1 (
      .clk          (clk),
      .reset_cpu    (reset_cpu),
      .output_port  (port1),
      .PC_below8bit (pc1),
      .freeze       (freeze1),
      .seg          (seg1),
      .an           (an1),
      .led          (led1),
      .frame_tick   (tick1)
   );

   typedef struct {
      logic [15:0]     val;
      logic [3:0][6:0] s;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       tick;
   } fast_t;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame_tick !== 1'b1 && n < 64);
      chk("tick_timeout", 32'(frame_tick), 32'd1);
   endtask

   task automatic scan(input logic [3:0][6:0] s, input int chg_at,
                       input logic [15:0] chg_val, input logic tick_end,
                       input logic [7:0] exp_led);
      int d;
      for (int i = 0; i < 16; i++) begin
         if (i == chg_at) output_port = chg_val;
         step();
         d = i / 4;
         chk("scan_seg", 32'(seg), 32'(s[d]));
         chk("scan_an", 32'(an), 32'(AN_EXP[d]));
         chk("scan_tick", 32'(frame_tick),
             32'((i == 15) ? tick_end : 1'b0));
         chk("scan_led", 32'(led), 32'(exp_led));
      end
   endtask

   vec_t  vecs[8];
   fast_t fast[8];

   initial begin
      vecs[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001}};
      vecs[1] = '{16'hFFFF, {7'b0001110, 7'b0001110, 7'b0001110,
                             7'b0001110}};
      vecs[2] = '{16'h0000, {LZ, LZ, LZ, 7'b1000000}};
      vecs[3] = '{16'h00A5, {LZ, LZ, 7'b0001000, 7'b0010010}};
      vecs[4] = '{16'h0BAD, {LZ, 7'b0000011, 7'b0001000,
                             7'b0100001}};
      vecs[5] = '{16'h8000, {7'b0000000, 7'b1000000, 7'b1000000,
                             7'b1000000}};
      vecs[6] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000}};
      vecs[7] = '{16'h9ECF, {7'b0010000, 7'b0000110, 7'b1000110,
                             7'b0001110}};

      fast[0] = '{4'b1110, 7'b1000000, 1'b0};
      fast[1] = '{4'b1101, LZ,         1'b0};
      fast[2] = '{4'b1011, LZ,         1'b0};
      fast[3] = '{4'b0111, LZ,         1'b1};
      fast[4] = '{4'b1110, 7'b0011001, 1'b0};
      fast[5] = '{4'b1101, 7'b0110000, 1'b0};
      fast[6] = '{4'b1011, 7'b0100100, 1'b0};
      fast[7] = '{4'b0111, 7'b1111001, 1'b1};

      reset_cpu   = 1'b1;
      output_port = 16'h0000;
      pc          = 8'h3C;
      freeze      = 1'b0;
      port1       = 16'h1234;
      pc1         = 8'hA7;
      freeze1     = 1'b0;
      step();
      step();
      chk("rst_seg", 32'(seg), 32'(BL));
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      chk("rst_seg1", 32'(seg1), 32'(BL));
      chk("rst_an1", 32'(an1), 32'hF);
      reset_cpu = 1'b0;

      for (int k = 0; k < 8; k++) begin
         step();
         chk("div1_an", 32'(an1), 32'(fast[k].an));
         chk("div1_seg", 32'(seg1), 32'(fast[k].seg));
         chk("div1_tick", 32'(tick1), 32'(fast[k].tick));
      end
      chk("div1_led", 32'(led1), 32'hA7);

      for (int v = 0; v < 8; v++) begin
         output_port = vecs[v].val;
         wait_tick();
         scan(vecs[v].s, -1, 16'h0, 1'b1, 8'h3C);
      end

      output_port = 16'h1234;
      wait_tick();
      scan(vecs[0].s, 5, 16'hFFFF, 1'b1, 8'h3C);
      scan(vecs[1].s, -1, 16'h0, 1'b1, 8'h3C);

      freeze      = 1'b1;
      output_port = 16'h0BAD;
      pc          = 8'h15;
      scan(vecs[1].s, -1, 16'h0, 1'b0, 8'h3C);
      freeze = 1'b0;
      step();
      chk("unfreeze_led", 32'(led), 32'h15);
      chk("unfreeze_tick", 32'(frame_tick), 32'h0);
      wait_tick();
      scan(vecs[4].s, -1, 16'h0, 1'b1, 8'h15);

      output_port = 16'h1234;
      for (int i = 0; i < 9; i++) step();
      reset_cpu = 1'b1;
      step();
      chk("midrst_seg", 32'(seg), 32'(BL));
      chk("midrst_an", 32'(an), 32'hF);
      chk("midrst_led", 32'(led), 32'h0);
      chk("midrst_tick", 32'(frame_tick), 32'h0);
      reset_cpu = 1'b0;
      scan(vecs[2].s, -1, 16'h0, 1'b1, 8'h15);
      scan(vecs[0].s, -1, 16'h0, 1'b1, 8'h15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
